// File: rtl/uop_add_sequencer.sv
// uop_add_sequencer: walks the point-addition microcode ROM and issues words to the modular engine.
// Optional engine-completion watchdog is enabled by defining UOP_SEQ_WDOG_EN.
module uop_add_sequencer #(
  parameter int ROM_AW      = 6,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic              op_valid,
  output logic [3:0]        op_opcode,
  output logic [3:0]        op_src1,
  output logic [3:0]        op_src2,
  output logic [3:0]        op_dst,
  input  logic              op_done,
  input  logic              op_eq,
  output logic [2:0]        cond,
  output logic              wdog_err
);

  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_RDY = 4'hF;

  localparam logic [3:0] EX_ALWAYS     = 4'h0;
  localparam logic [3:0] EX_PZT1T2_0XX = 4'h1;
  localparam logic [3:0] EX_PZT1T2_100 = 4'h2;
  localparam logic [3:0] EX_PZT1T2_101 = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] cmp_idx;
  logic       exec_ok;
  logic       last_addr;
  logic       wdog_fire;

  assign last_addr = (rom_addr == {ROM_AW{1'b1}});

  always_comb begin
    exec_ok = 1'b0;
    case (rom_data[3:0])
      EX_ALWAYS:     exec_ok = 1'b1;
      EX_PZT1T2_0XX: exec_ok = ~cond[2];
      EX_PZT1T2_100: exec_ok = (cond == 3'b100);
      EX_PZT1T2_101: exec_ok = (cond == 3'b101);
      default:       exec_ok = 1'b0;
    endcase
  end

`ifdef UOP_SEQ_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

  logic [WDW-1:0] wdog_cnt;

  assign wdog_fire = (state == S_WAIT) && !op_done && (wdog_cnt == WDOG_LAST);

  // Counter restarts on every new engine request; the error stays set until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == S_WAIT) wdog_cnt <= wdog_cnt + 1'b1;
      else                 wdog_cnt <= '0;
      if (wdog_fire)                      wdog_err <= 1'b1;
      else if (state == S_IDLE && start)  wdog_err <= 1'b0;
    end
  end
`else
  assign wdog_fire = 1'b0;
  // Always low here; WDOG_CYCLES only matters for the watchdog build.
  assign wdog_err  = (WDOG_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      op_valid  <= 1'b0;
      op_opcode <= '0;
      op_src1   <= '0;
      op_src2   <= '0;
      op_dst    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cond      <= 3'b000;
      cmp_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            rom_addr <= '0;
            cmp_idx  <= '0;
            cond     <= 3'b000;
          end
        end
        S_FETCH:    state <= S_WAIT_ROM;
        S_WAIT_ROM: state <= S_DECODE;
        S_DECODE: begin
          if (rom_data[19:16] == OP_RDY) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (exec_ok) begin
            state <= S_ISSUE;
          end else if (last_addr) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        S_ISSUE: begin
          op_valid  <= 1'b1;
          op_opcode <= rom_data[19:16];
          op_src1   <= rom_data[15:12];
          op_src2   <= rom_data[11:8];
          op_dst    <= rom_data[7:4];
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (op_done) begin
            op_valid <= 1'b0;
            // CMP results fill cond from the top bit down: PZ, then T1, then T2.
            if (op_opcode == OP_CMP && cmp_idx != 2'd3) begin
              case (cmp_idx)
                2'd0:    cond[2] <= ~op_eq;
                2'd1:    cond[1] <= ~op_eq;
                default: cond[0] <= ~op_eq;
              endcase
              cmp_idx <= cmp_idx + 1'b1;
            end
            if (last_addr) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= S_FETCH;
            end
          end else if (wdog_fire) begin
            op_valid <= 1'b0;
            state    <= S_DONE;
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_add_sequencer.sv
// tb_uop_add_sequencer: ROM and engine models around the sequencer; issued words are checked
// against a scoreboard filled from the expected-issue mask of each vector.
module tb_uop_add_sequencer;

  localparam int ROM_AW  = 6;
  localparam int WDOG    = 16;
  localparam int ENG_LAT = 5;

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_CMP = 4'h3, OP_MUL = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5, OP_RDY = 4'hF;
  localparam logic [3:0] EX_ALWAYS = 4'h0, EX_0XX = 4'h1, EX_100 = 4'h2, EX_101 = 4'h3;
  localparam logic [3:0] R_X = 4'd0, R_Y = 4'd1, R_Z = 4'd2, G_X = 4'd8, G_Y = 4'd9;
  localparam logic [3:0] ONE = 4'd10, ZERO = 4'd11;

  logic              clk, rst, start;
  logic              busy, done, op_valid, op_done, op_eq, wdog_err;
  logic [ROM_AW-1:0] rom_addr;
  logic [19:0]       rom_data;
  logic [3:0]        op_opcode, op_src1, op_src2, op_dst;
  logic [2:0]        cond;

  uop_add_sequencer #(.ROM_AW(ROM_AW), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .op_valid(op_valid),
    .op_opcode(op_opcode), .op_src1(op_src1), .op_src2(op_src2), .op_dst(op_dst),
    .op_done(op_done), .op_eq(op_eq), .cond(cond), .wdog_err(wdog_err)
  );

  typedef struct packed {
    logic [5:0] addr;
    logic [3:0] opc;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] d;
  } issue_t;

  typedef struct {
    string       name;
    logic [3:0]  eq_plan;
    logic [2:0]  exp_cond;
    logic [63:0] issue_mask;
  } vec_t;

  logic [19:0] rom [64];
  logic [5:0]  prev_addr;
  issue_t      sb[$];
  vec_t        vecs[4];

  int total = 0, bad = 0;
  int done_count = 0, issue_n = 0, cmp_n = 0, hang_addr = -1;
  int eng_cnt = 0;
  bit eng_busy = 0, eng_hang = 0;
  logic [3:0] eq_plan = 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic [3:0] d,
                                     input logic [3:0] ex);
    return {op, s1, s2, d, ex};
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Registered ROM: data for the address held during a cycle appears after the next edge.
  initial begin
    rom_data  = '0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      rom_data  = rom[prev_addr];
      prev_addr = rom_addr;
    end
  end

  // Engine model: accepts a request, checks it against the scoreboard, answers ENG_LAT clocks later.
  initial begin
    op_done = 1'b0;
    op_eq   = 1'b0;
    forever begin
      @(negedge clk);
      op_done = 1'b0;
      op_eq   = 1'b0;
      if (rst) begin
        eng_busy = 0;
        eng_hang = 0;
      end else if (eng_busy && !op_valid) begin
        eng_busy = 0;
        eng_hang = 0;
      end else if (eng_busy) begin
        eng_cnt++;
      end else if (op_valid) begin
        issue_t act, exp;
        eng_busy = 1;
        eng_cnt  = 1;
        issue_n++;
        eng_hang = (int'(rom_addr) == hang_addr);
        act = '{rom_addr, op_opcode, op_src1, op_src2, op_dst};
        if (sb.size() == 0) begin
          checkOutput("issue_unexpected", 64'(act), 64'(0));
        end else begin
          exp = sb.pop_front();
          checkOutput("issue_order", 64'(act), 64'(exp));
        end
      end
      if (eng_busy && !eng_hang && eng_cnt == ENG_LAT) begin
        op_done = 1'b1;
        if (op_opcode == OP_CMP) begin
          if (cmp_n < 4) op_eq = eq_plan[cmp_n];
          cmp_n++;
        end
        eng_busy = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_count++;
    end
  end

  task automatic loadMain();
    for (int a = 0; a < 64; a++) begin
      logic [5:0] av = 6'(a);
      logic [5:0] a1 = 6'(a + 1);
      logic [5:0] a2 = 6'(a + 2);
      logic [3:0] op;
      if (a == 5 || a == 15 || a == 20) op = OP_CMP;
      else if (a % 3 == 0)             op = OP_ADD;
      else if (a % 3 == 1)             op = OP_MUL;
      else                             op = OP_SUB;
      rom[a] = mk(op, av[3:0], a1[3:0], a2[3:0], EX_ALWAYS);
    end
    rom[24] = mk(OP_MOV, G_X, ZERO, R_X, EX_0XX);
    rom[25] = mk(OP_MOV, G_Y, ZERO, R_Y, EX_0XX);
    rom[26] = mk(OP_MOV, ONE, ZERO, R_Z, EX_0XX);
    rom[27] = mk(OP_MOV, 4'd12, ZERO, R_X, EX_100);
    rom[28] = mk(OP_MOV, 4'd13, ZERO, R_Y, EX_100);
    rom[29] = mk(OP_MOV, 4'd14, ZERO, R_Z, EX_100);
    rom[30] = mk(OP_MOV, ONE, ZERO, R_X, EX_101);
    rom[31] = mk(OP_MOV, ONE, ZERO, R_Y, EX_101);
    rom[32] = mk(OP_MOV, ZERO, ZERO, R_Z, EX_101);
    rom[33] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, EX_ALWAYS);
  endtask

  task automatic pushMask(input logic [63:0] m);
    sb.delete();
    for (int a = 0; a < 64; a++) begin
      if (m[a]) begin
        logic [19:0] w = rom[a];
        sb.push_back('{6'(a), w[19:16], w[15:12], w[11:8], w[7:4]});
      end
    end
  endtask

  // Pulse start, wait (bounded) for done, optionally re-pulse start in the done cycle.
  task automatic applyStimulus(input string name, input int budget, input bit start_on_done);
    int base = done_count;
    int waited = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput({name, "_busy_high"}, 64'(busy), 64'(1));
    while (done !== 1'b1 && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({name, "_timeout"}, 64'(waited >= budget), 64'(0));
    if (start_on_done) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, "_busy_low"}, 64'(busy), 64'(0));
    checkOutput({name, "_done_once"}, 64'(done_count - base), 64'(1));
  endtask

  initial begin
    int waited;
    rst   = 1'b1;
    start = 1'b0;
    for (int a = 0; a < 64; a++) rom[a] = '0;
    loadMain();

    vecs[0] = '{"generic",    4'b0000, 3'b111, rng(0, 23)};
    vecs[1] = '{"pz_zero",    4'b0001, 3'b011, rng(0, 26)};
    vecs[2] = '{"p_eq_g",     4'b0110, 3'b100, rng(0, 23) | rng(27, 29)};
    vecs[3] = '{"p_eq_neg_g", 4'b0010, 3'b101, rng(0, 23) | rng(30, 32)};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 64'({busy, done, rom_addr, op_valid, op_opcode, op_src1,
                                    op_src2, op_dst, cond, wdog_err}), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 64'({busy, op_valid}), 64'(0));

    for (int v = 0; v < 4; v++) begin
      eq_plan = vecs[v].eq_plan;
      cmp_n   = 0;
      issue_n = 0;
      pushMask(vecs[v].issue_mask);
      applyStimulus(vecs[v].name, 2000, v == 3);
      checkOutput({vecs[v].name, "_cond"}, 64'(cond), 64'(vecs[v].exp_cond));
      checkOutput({vecs[v].name, "_left"}, 64'(sb.size()), 64'(0));
      checkOutput({vecs[v].name, "_wdog"}, 64'(wdog_err), 64'(0));
    end

    // Reset while waiting on the engine at address 10, with stray starts beforehand.
    $display("[TB] reset mid-program");
    eq_plan = 4'b0000;
    cmp_n   = 0;
    pushMask(rng(0, 9));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waited = 0;
    while (!(op_valid && rom_addr == 6'd10) && waited < 2000) begin
      start = (waited == 20 || waited == 40);
      @(posedge clk); #1;
      waited++;
    end
    start = 1'b0;
    checkOutput("rst_reach_addr10", 64'(waited >= 2000), 64'(0));
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_state", 64'({busy, done, rom_addr, op_valid, op_opcode, op_src1,
                                      op_src2, op_dst, cond, wdog_err}), 64'(0));
    checkOutput("rst_mid_left", 64'(sb.size()), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_no_restart", 64'(busy), 64'(0));

    // Four CMPs: the fourth must not touch cond.
    $display("[TB] cmp saturation");
    for (int a = 0; a < 4; a++) rom[a] = mk(OP_CMP, 4'(a), 4'(a + 4), 4'd0, EX_ALWAYS);
    rom[4] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, EX_ALWAYS);
    eq_plan = 4'b0101;
    cmp_n   = 0;
    pushMask(rng(0, 3));
    applyStimulus("sat", 500, 0);
    checkOutput("sat_cond", 64'(cond), 64'(3'b010));
    checkOutput("sat_left", 64'(sb.size()), 64'(0));

    // No RDY and nothing executable: must stop at the last address, not wrap.
    $display("[TB] address wrap");
    for (int a = 0; a < 64; a++) rom[a] = mk(OP_ADD, 4'd1, 4'd2, 4'd3, 4'h9);
    rom[1] = mk(OP_MOV, ONE, ZERO, R_X, EX_100);
    rom[2] = mk(OP_MOV, ONE, ZERO, R_Y, EX_101);
    issue_n = 0;
    sb.delete();
    applyStimulus("wrap", 600, 0);
    checkOutput("wrap_addr", 64'(rom_addr), 64'(63));
    checkOutput("wrap_no_issue", 64'(issue_n), 64'(0));

`ifdef UOP_SEQ_WDOG_EN
    begin
      int hi = 0;
      int base;
      $display("[TB] watchdog");
      loadMain();
      eq_plan   = 4'b0000;
      cmp_n     = 0;
      hang_addr = 3;
      pushMask(rng(0, 3));
      base = done_count;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      waited = 0;
      while (!(op_valid && rom_addr == 6'd3) && waited < 500) begin
        @(posedge clk); #1;
        waited++;
      end
      checkOutput("wdog_reach_addr3", 64'(waited >= 500), 64'(0));
      while (op_valid && hi < 100) begin
        hi++;
        @(posedge clk); #1;
      end
      checkOutput("wdog_valid_cycles", 64'(hi), 64'(WDOG));
      checkOutput("wdog_err_set", 64'(wdog_err), 64'(1));
      checkOutput("wdog_done", 64'(done), 64'(1));
      @(posedge clk); #1;
      checkOutput("wdog_done_once", 64'(done_count - base), 64'(1));
      checkOutput("wdog_err_sticky", 64'({wdog_err, busy}), 64'(2'b10));
      hang_addr = -1;
      checkOutput("wdog_left", 64'(sb.size()), 64'(0));
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checkOutput("wdog_err_cleared", 64'(wdog_err), 64'(0));
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
    end
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
